// File: rtl/serial_add_seq.sv
// Sequencer for a downstream bit-serial adder: accepts an operand pair, pulses load,
// shifts WIDTH cycles, captures the sum and holds it until the consumer takes it.
module serial_add_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             add_load,
    output logic             add_shift,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [7:0]       done_cnt
);

    // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StCapture,
        StHold
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [7:0]       done_q, done_d;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            done_q  <= done_d;
        end
    end

    // Next-state, datapath updates and state-decoded strobes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        done_d    = done_q;
        in_ready  = 1'b0;
        add_load  = 1'b0;
        add_shift = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                add_load = 1'b1;
                cnt_d    = '0;
                state_d  = StShift;
            end
            StShift: begin
                add_shift = 1'b1;
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCapture: begin
                // Adder has completed all WIDTH shifts; carry-out is not kept.
                sum_d   = add_sum;
                done_d  = done_q + 8'd1;
                state_d = StHold;
            end
            StHold: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign add_a    = a_q;
    assign add_b    = b_q;
    assign out_sum  = sum_q;
    assign done_cnt = done_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq with a behavioural LSB-first serial adder attached.
module tb_serial_add_seq;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       add_load;
    logic       add_shift;
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic [3:0] add_sum;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_sum;
    logic [7:0] done_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    serial_add_seq #(
        .WIDTH(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .add_load (add_load),
        .add_shift(add_shift),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_sum  (add_sum),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .done_cnt (done_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream serial adder: load clears the sum, each shift adds one bit LSB first.
    logic [3:0] ma, mb, ms;
    logic       mc;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ma <= '0;
            mb <= '0;
            ms <= '0;
            mc <= 1'b0;
        end else if (add_load) begin
            ma <= add_a;
            mb <= add_b;
            ms <= '0;
            mc <= 1'b0;
        end else if (add_shift) begin
            ms <= {ma[0] ^ mb[0] ^ mc, ms[3:1]};
            ma <= ma >> 1;
            mb <= mb >> 1;
            mc <= (ma[0] & mb[0]) | (mc & (ma[0] ^ mb[0]));
        end
    end
    assign add_sum = ms;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one pair from IDLE and follow it into HOLD. Latency counts the offer cycle as 0.
    task automatic do_add(input logic [3:0] a, input logic [3:0] b, input logic [3:0] exp_sum,
                          input logic [7:0] exp_cnt, input logic hold_valid, input logic rdy);
        int lat, loads, shifts, both, opnd_bad;
        lat = 1; loads = 0; shifts = 0; both = 0; opnd_bad = 0;
        out_ready = rdy;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        tick();
        check("latched_a", 32'(add_a), 32'(a));
        check("latched_b", 32'(add_b), 32'(b));
        if (hold_valid) begin
            in_a = ~a;
            in_b = ~b;
        end else begin
            in_valid = 1'b0;
        end
        while (!out_valid && lat < 20) begin
            loads  += int'(add_load);
            shifts += int'(add_shift);
            if (add_load && add_shift) both++;
            if (add_a !== a || add_b !== b || in_ready) opnd_bad++;
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'd7);
        check("load_cycles", 32'(loads), 32'd1);
        check("shift_cycles", 32'(shifts), 32'd4);
        check("load_shift_overlap", 32'(both), 32'd0);
        check("operands_stable", 32'(opnd_bad), 32'd0);
        check("out_sum", 32'(out_sum), 32'(exp_sum));
        check("done_cnt", 32'(done_cnt), 32'(exp_cnt));
        check("hold_a", 32'(add_a), 32'(a));
        check("hold_in_ready", 32'(in_ready), 32'd0);
        check("hold_strobes", 32'({add_load, add_shift}), 32'd0);
    endtask

    int k, pulses, cyc, last, gap_bad, sum_bad, bad;
    logic [3:0] eq[$];
    logic [3:0] e;

    initial begin
        reset = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_strobes", 32'({add_load, add_shift, out_valid}), 32'd0);
        check("rst_ops", 32'({add_a, add_b}), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_done_cnt", 32'(done_cnt), 32'd0);
        reset = 1'b1;
        tick();
        check("release_no_accept", 32'(in_ready), 32'd1);

        // 1101 + 0010 = 1111
        do_add(4'b1101, 4'b0010, 4'b1111, 8'd1, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        check("back_to_idle", 32'(in_ready), 32'd1);
        check("valid_dropped", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // New operands offered throughout are ignored until IDLE is reached again
        do_add(4'h5, 4'h6, 4'hB, 8'd2, 1'b1, 1'b0);
        out_ready = 1'b1;
        tick();
        check("no_accept_from_hold", 32'(add_a), 32'h5);
        check("idle_after_hold", 32'(in_ready), 32'd1);
        // Pending ~5/~6 = A/9 gets accepted now; out_ready high early has no effect
        do_add(4'hA, 4'h9, 4'h3, 8'd3, 1'b0, 1'b1);
        tick();
        out_ready = 1'b0;

        // F + 1 wraps to 0, held while out_ready stays low
        do_add(4'hF, 4'h1, 4'h0, 8'd4, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_a = 4'h3;
        in_b = 4'h3;
        bad = 0;
        repeat (10) begin
            tick();
            if (!out_valid || out_sum !== 4'h0 || in_ready || done_cnt !== 8'd4) bad++;
        end
        check("hold_stable", 32'(bad), 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        // Reset during the third shift cycle
        in_a = 4'h9;
        in_b = 4'h9;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("in_third_shift", 32'(add_shift), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_strobes", 32'({add_load, add_shift, out_valid}), 32'd0);
        check("async_ops", 32'({add_a, add_b}), 32'd0);
        check("async_out_sum", 32'(out_sum), 32'd0);
        check("async_done_cnt", 32'(done_cnt), 32'd0);
        check("async_in_ready", 32'(in_ready), 32'd1);
        bad = 0;
        repeat (3) begin
            tick();
            if (out_valid || done_cnt !== 8'd0) bad++;
        end
        check("abort_no_result", 32'(bad), 32'd0);
        reset = 1'b1;
        tick();
        check("post_reset_idle", 32'({in_ready, add_load}), 32'b10);
        do_add(4'h3, 4'h4, 4'h7, 8'd1, 1'b0, 1'b1);
        tick();
        out_ready = 1'b0;

        // 256 back-to-back additions
        reset = 1'b0;
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        k = 0; pulses = 0; cyc = 0; last = -1; gap_bad = 0; sum_bad = 0;
        while (pulses < 256 && cyc < 3000) begin
            if (in_ready) begin
                if (k < 256) begin
                    in_valid = 1'b1;
                    in_a = 4'(k);
                    in_b = 4'(k >> 4);
                    e = 4'(k) + 4'(k >> 4);
                    eq.push_back(e);
                    k++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            tick();
            cyc++;
            if (out_valid) begin
                pulses++;
                if (eq.size() > 0) begin
                    e = eq.pop_front();
                    if (out_sum !== e) sum_bad++;
                end else begin
                    sum_bad++;
                end
                if (last >= 0 && cyc - last != 8) gap_bad++;
                last = cyc;
                if (pulses == 255) check("done_cnt_255", 32'(done_cnt), 32'd255);
            end
        end
        in_valid = 1'b0;
        check("b2b_pulses", 32'(pulses), 32'd256);
        check("b2b_spacing", 32'(gap_bad), 32'd0);
        check("b2b_sums", 32'(sum_bad), 32'd0);
        check("done_cnt_wrap", 32'(done_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_add_seq.md
SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 Parameter: WIDTH, default 4, operand and sum width in bits; equals the number of shift cycles per addition.
REQ-002 Ports, one per line:
  clk        input   1      single clock; all state updates on rising edge
  reset      input   1      asynchronous, active-low reset
  in_valid   input   1      operand pair on in_a/in_b is offered
  in_ready   output  1      block can accept an operand pair
  in_a       input   WIDTH  operand A
  in_b       input   WIDTH  operand B
  add_load   output  1      load strobe to downstream serial_adder
  add_shift  output  1      shift enable to downstream serial_adder
  add_a      output  WIDTH  latched operand A presented to serial_adder
  add_b      output  WIDTH  latched operand B presented to serial_adder
  add_sum    input   WIDTH  sum returned by serial_adder
  out_valid  output  1      out_sum holds a completed result
  out_ready  input   1      consumer accepts the result
  out_sum    output  WIDTH  captured result
  done_cnt   output  8      completed-result counter

Function
REQ-003 The FSM SHALL have states IDLE, LOAD, SHIFT, CAPTURE and HOLD.
REQ-004 in_ready SHALL be 1 only in IDLE; the block SHALL ignore in_valid in every other state.
REQ-005 In IDLE, on in_valid&in_ready, in_a/in_b SHALL be latched into add_a/add_b and the FSM SHALL go to LOAD.
REQ-006 In LOAD, add_load SHALL be 1 for exactly one cycle, and the FSM SHALL then go to SHIFT with the shift counter at 0.
REQ-007 In SHIFT, add_shift SHALL be 1 for exactly WIDTH consecutive cycles, with the counter incrementing each cycle; on counter==WIDTH-1 the FSM SHALL go to CAPTURE.
REQ-008 add_load and add_shift SHALL never both be 1 in the same cycle, and both SHALL be 0 in IDLE, CAPTURE and HOLD.
REQ-009 add_a/add_b SHALL hold the latched operands unchanged from LOAD through HOLD.
REQ-010 In CAPTURE, out_sum SHALL register add_sum, done_cnt SHALL increment, and the FSM SHALL go to HOLD.
REQ-011 out_valid SHALL be 1 exactly in HOLD; out_sum SHALL be stable while out_valid=1.
REQ-012 In HOLD, on out_ready=1 the FSM SHALL go to IDLE on the next edge, with no same-cycle bypass to a new accept.
REQ-013 out_ready asserted while out_valid=0 SHALL have no effect.
REQ-014 Latency: out_valid SHALL rise WIDTH+3 cycles after the accepting edge, which is 7 for WIDTH=4.
REQ-015 Throughput: one addition per WIDTH+4 cycles minimum, which is 8 for WIDTH=4 with out_ready held at 1.
REQ-016 out_sum SHALL equal (in_a+in_b) mod 2^WIDTH; carry-out SHALL be discarded.
REQ-017 done_cnt SHALL wrap from 255 to 0.

Reset
REQ-018 While reset=0, the FSM SHALL be in IDLE, and in_ready SHALL be 1.
REQ-019 While reset=0, add_load, add_shift, out_valid, add_a, add_b, out_sum, done_cnt and the shift counter SHALL all be 0.
REQ-020 Reset asserted mid-operation in any state SHALL abort the operation immediately, without an out_valid pulse and without a done_cnt increment.
REQ-021 Reset deassertion SHALL take effect on the next rising edge of clk; no operand SHALL be accepted on that edge unless in_valid=1.

Verification
REQ-022 Offer a=4'b1101, b=4'b0010 -> add_load pulses 1 cycle, add_shift high 4 cycles, out_valid at +7 with out_sum=4'b1111, done_cnt=1.
REQ-023 Offer a=4'hF, b=4'h1 with out_ready=0 for 10 cycles -> out_sum=4'h0 held stable, out_valid held, in_ready=0 throughout.
REQ-024 Keep in_valid=1 with new operands during SHIFT -> operands ignored; add_a/add_b unchanged; the next accept occurs only after return to IDLE.
REQ-025 Assert reset=0 during the third shift cycle -> all outputs 0 asynchronously; no out_valid; after release, a=4'h3, b=4'h4 gives out_sum=4'h7.
REQ-026 Run 256 back-to-back additions with out_ready=1 -> 8-cycle spacing between out_valid pulses; done_cnt wraps to 0.
